// File: rtl/mips_decode_pipe.sv
// Registered MIPS decode stage: load-use bubbles, valid/ready input, two-phase addm.
// Define MIPS_DECODE_ADDM_EN to enable the addm micro-sequence (funct 0x2c).
module mips_decode_pipe #(
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic                zero,
  output logic                out_valid,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                writeenable,
  output logic                rd_src,
  output logic                except,
  output logic                mem_read,
  output logic                word_we,
  output logic                byte_we,
  output logic                byte_load,
  output logic                slt,
  output logic                lui,
  output logic                addm,
  output logic [1:0]          alu_src2,
  output logic [1:0]          control_type,
  output logic [REG_W-1:0]    dest_reg,
  output logic                bubble
);

`ifdef MIPS_DECODE_ADDM_EN
  typedef enum logic [1:0] {RUN, BUBBLE, ADDM2} state_t;
  localparam logic [5:0] F_ADDM = 6'h2c;
`else
  typedef enum logic [1:0] {RUN, BUBBLE} state_t;
`endif

  typedef struct packed {
    logic                out_valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic                writeenable, rd_src, except, mem_read, word_we;
    logic                byte_we, byte_load, slt, lui, addm;
    logic [1:0]          alu_src2, control_type;
    logic [REG_W-1:0]    dest_reg;
    logic                bubble;
  } bundle_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI = 6'h0f, OP_LW = 6'h23, OP_LBU = 6'h24, OP_SB = 6'h28, OP_SW = 6'h2b;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a, F_JR = 6'h08;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2), ALU_SUB = ALU_OP_W'(3), ALU_AND = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_OR = ALU_OP_W'(5), ALU_NOR = ALU_OP_W'(6), ALU_XOR = ALU_OP_W'(7);

  logic [5:0]       opcode, funct;
  logic [REG_W-1:0] rs_x, rt_x, rd_x;
  logic             unused_shamt;
  bundle_t          dec, out_d, out_q;
  state_t           state_d, state_q;
  logic [1:0]       cnt_d, cnt_q;
  logic             reads_rs, reads_rt, hit;
`ifdef MIPS_DECODE_ADDM_EN
  logic [REG_W-1:0] addm_rd_d, addm_rd_q;
`endif

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rs_x         = REG_W'(instr[25:21]);
  assign rt_x         = REG_W'(instr[20:16]);
  assign rd_x         = REG_W'(instr[15:11]);
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    // NOTE: every field gets a default first so no decode path can infer a latch.
    dec           = '0;
    dec.out_valid = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   begin dec.alu_op = ALU_ADD; dec.writeenable = 1'b1; end
          F_SUB:   begin dec.alu_op = ALU_SUB; dec.writeenable = 1'b1; end
          F_AND:   begin dec.alu_op = ALU_AND; dec.writeenable = 1'b1; end
          F_OR:    begin dec.alu_op = ALU_OR;  dec.writeenable = 1'b1; end
          F_XOR:   begin dec.alu_op = ALU_XOR; dec.writeenable = 1'b1; end
          F_NOR:   begin dec.alu_op = ALU_NOR; dec.writeenable = 1'b1; end
          F_SLT:   begin dec.alu_op = ALU_SUB; dec.writeenable = 1'b1; dec.slt = 1'b1; end
          F_JR:    dec.control_type = 2'd3;
`ifdef MIPS_DECODE_ADDM_EN
          F_ADDM:  begin dec.alu_op = ALU_ADD; dec.mem_read = 1'b1; dec.addm = 1'b1; end
`endif
          default: dec.except = 1'b1;
        endcase
      end
      OP_J:    dec.control_type = 2'd2;
      OP_BEQ:  begin dec.alu_op = ALU_SUB; dec.control_type = zero ? 2'd1 : 2'd0; end
      OP_BNE:  begin dec.alu_op = ALU_SUB; dec.control_type = zero ? 2'd0 : 2'd1; end
      OP_ADDI: begin dec.alu_op = ALU_ADD; dec.alu_src2 = 2'd1; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
      OP_ANDI: begin dec.alu_op = ALU_AND; dec.alu_src2 = 2'd2; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
      OP_ORI:  begin dec.alu_op = ALU_OR;  dec.alu_src2 = 2'd2; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
      OP_XORI: begin dec.alu_op = ALU_XOR; dec.alu_src2 = 2'd2; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
      OP_LUI:  begin dec.lui = 1'b1; dec.alu_src2 = 2'd2; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
      OP_LW, OP_LBU: begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src2    = 2'd1;
        dec.mem_read    = 1'b1;
        dec.writeenable = 1'b1;
        dec.rd_src      = 1'b1;
        dec.byte_load   = (opcode == OP_LBU);
      end
      OP_SW:   begin dec.alu_op = ALU_ADD; dec.alu_src2 = 2'd1; dec.word_we = 1'b1; end
      OP_SB:   begin dec.alu_op = ALU_ADD; dec.alu_src2 = 2'd1; dec.byte_we = 1'b1; end
      default: dec.except = 1'b1;
    endcase
    dec.dest_reg = !dec.writeenable ? '0 : (dec.rd_src ? rt_x : rd_x);
  end

  // A load sitting in the output register is the only producer that can cause a hit.
  assign reads_rs = !(opcode == OP_J || opcode == OP_LUI);
  assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                    (opcode == OP_SW) || (opcode == OP_SB);
  assign hit = in_valid && (state_q == RUN) && out_q.mem_read && out_q.writeenable &&
               (out_q.dest_reg != '0) &&
               ((reads_rs && rs_x == out_q.dest_reg) || (reads_rt && rt_x == out_q.dest_reg));
  assign in_ready = !reset && (state_q == RUN) && !hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
`ifdef MIPS_DECODE_ADDM_EN
    addm_rd_d = addm_rd_q;
`endif
    case (state_q)
      RUN: begin
        if (hit) begin
          // The hit cycle itself counts as the first bubble.
          out_d.out_valid = 1'b1;
          out_d.bubble    = 1'b1;
          cnt_d           = 2'(LOAD_LAT - 1);
          if (LOAD_LAT > 1) state_d = BUBBLE;
        end else if (in_valid) begin
          out_d = dec;
`ifdef MIPS_DECODE_ADDM_EN
          if (dec.addm) begin
            state_d   = ADDM2;
            addm_rd_d = rd_x;
          end
`endif
        end
      end
      BUBBLE: begin
        out_d.out_valid = 1'b1;
        out_d.bubble    = 1'b1;
        cnt_d           = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = RUN;
      end
`ifdef MIPS_DECODE_ADDM_EN
      ADDM2: begin
        out_d.out_valid   = 1'b1;
        out_d.writeenable = 1'b1;
        out_d.addm        = 1'b1;
        out_d.dest_reg    = addm_rd_q;
        state_d           = RUN;
      end
`endif
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef MIPS_DECODE_ADDM_EN
      addm_rd_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef MIPS_DECODE_ADDM_EN
      addm_rd_q <= addm_rd_d;
`endif
    end
  end

  assign out_valid    = out_q.out_valid;
  assign alu_op       = out_q.alu_op;
  assign writeenable  = out_q.writeenable;
  assign rd_src       = out_q.rd_src;
  assign except       = out_q.except;
  assign mem_read     = out_q.mem_read;
  assign word_we      = out_q.word_we;
  assign byte_we      = out_q.byte_we;
  assign byte_load    = out_q.byte_load;
  assign slt          = out_q.slt;
  assign lui          = out_q.lui;
  assign addm         = out_q.addm;
  assign alu_src2     = out_q.alu_src2;
  assign control_type = out_q.control_type;
  assign dest_reg     = out_q.dest_reg;
  assign bubble       = out_q.bubble;

endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed scoreboard bench for mips_decode_pipe; one instance with LOAD_LAT=1, one with LOAD_LAT=3.
module tb_mips_decode_pipe;

  typedef struct packed {
    logic       out_valid;
    logic [2:0] alu_op;
    logic       writeenable, rd_src, except, mem_read, word_we;
    logic       byte_we, byte_load, slt, lui, addm;
    logic [1:0] alu_src2, control_type;
    logic [4:0] dest_reg;
    logic       bubble;
  } bundle_t;

  logic        clk, reset;
  logic        in_valid1, zero1, in_ready1, in_valid3, zero3, in_ready3;
  logic [31:0] instr1, instr3;
  bundle_t     obs1, obs3;
  bundle_t     sb_q[$];
  int          n_pass, n_fail, n_total;

  mips_decode_pipe #(.REG_W(5), .ALU_OP_W(3), .LOAD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .instr(instr1), .zero(zero1), .out_valid(obs1.out_valid), .alu_op(obs1.alu_op),
    .writeenable(obs1.writeenable), .rd_src(obs1.rd_src), .except(obs1.except),
    .mem_read(obs1.mem_read), .word_we(obs1.word_we), .byte_we(obs1.byte_we),
    .byte_load(obs1.byte_load), .slt(obs1.slt), .lui(obs1.lui), .addm(obs1.addm),
    .alu_src2(obs1.alu_src2), .control_type(obs1.control_type),
    .dest_reg(obs1.dest_reg), .bubble(obs1.bubble)
  );

  mips_decode_pipe #(.REG_W(5), .ALU_OP_W(3), .LOAD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .instr(instr3), .zero(zero3), .out_valid(obs3.out_valid), .alu_op(obs3.alu_op),
    .writeenable(obs3.writeenable), .rd_src(obs3.rd_src), .except(obs3.except),
    .mem_read(obs3.mem_read), .word_we(obs3.word_we), .byte_we(obs3.byte_we),
    .byte_load(obs3.byte_load), .slt(obs3.slt), .lui(obs3.lui), .addm(obs3.addm),
    .alu_src2(obs3.alu_src2), .control_type(obs3.control_type),
    .dest_reg(obs3.dest_reg), .bubble(obs3.bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic bundle_t b_alu(logic [2:0] op, logic [4:0] d);
    bundle_t b = '0;
    b.out_valid = 1'b1; b.alu_op = op; b.writeenable = 1'b1; b.dest_reg = d;
    return b;
  endfunction

  function automatic bundle_t b_br(logic taken);
    bundle_t b = '0;
    b.out_valid = 1'b1; b.alu_op = 3'd3; b.control_type = taken ? 2'd1 : 2'd0;
    return b;
  endfunction

  function automatic bundle_t b_load(logic [4:0] d, logic is_byte);
    bundle_t b = '0;
    b.out_valid = 1'b1; b.alu_op = 3'd2; b.alu_src2 = 2'd1; b.mem_read = 1'b1;
    b.writeenable = 1'b1; b.rd_src = 1'b1; b.dest_reg = d; b.byte_load = is_byte;
    return b;
  endfunction

  function automatic bundle_t b_bub();
    bundle_t b = '0;
    b.out_valid = 1'b1; b.bubble = 1'b1;
    return b;
  endfunction

  function automatic bundle_t b_exc();
    bundle_t b = '0;
    b.out_valid = 1'b1; b.except = 1'b1;
    return b;
  endfunction

  task automatic check_b(input string tag, input bundle_t got, input bundle_t exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_r(input string tag, input logic got, input logic exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed in_ready=%b expected %b", tag, got, exp);
    end
  endtask

  // One clock: drive, check in_ready, queue the expected bundle, then compare after the edge.
  task automatic cyc(input bit sel, input bit v, input logic [31:0] ins, input bit z,
                     input bit rdy, input bundle_t exp, input string tag);
    if (sel) begin in_valid3 = v; instr3 = ins; zero3 = z; end
    else     begin in_valid1 = v; instr1 = ins; zero1 = z; end
    #1;
    check_r({tag, "_rdy"}, sel ? in_ready3 : in_ready1, rdy);
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    check_b(tag, sel ? obs3 : obs1, sb_q.pop_front());
  endtask

  logic [31:0] add_321, add_652, add_678, add_600, add_652b, lw5, lw0, lbu9, add_10_99;
  bundle_t     e;

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    reset = 1'b1;
    in_valid1 = 1'b0; instr1 = '0; zero1 = 1'b0;
    in_valid3 = 1'b0; instr3 = '0; zero3 = 1'b0;
    add_321   = 32'h0022_1820;
    add_652   = rtype(5, 2, 6, 6'h20);
    add_652b  = rtype(2, 5, 6, 6'h20);
    add_678   = rtype(7, 8, 6, 6'h20);
    add_600   = rtype(0, 0, 6, 6'h20);
    add_10_99 = rtype(9, 9, 10, 6'h20);
    lw5       = itype(6'h23, 1, 5, 16'h0000);
    lw0       = itype(6'h23, 1, 0, 16'h0000);
    lbu9      = itype(6'h24, 5, 9, 16'h0004);

    repeat (2) @(posedge clk);
    #1;
    check_b("rst_out1", obs1, '0);
    check_b("rst_out3", obs3, '0);
    check_r("rst_rdy1", in_ready1, 1'b0);
    reset = 1'b0;
    #1;
    check_r("rst_release_rdy1", in_ready1, 1'b1);

    // ALU ops and branches
    cyc(0, 1, add_321, 0, 1, b_alu(3'd2, 5'd3), "add");
    cyc(0, 1, itype(6'h04, 1, 2, 16'h0004), 1, 1, b_br(1'b1), "beq_z1");
    cyc(0, 1, itype(6'h04, 1, 2, 16'h0004), 0, 1, b_br(1'b0), "beq_z0");
    cyc(0, 1, itype(6'h05, 1, 2, 16'h0004), 0, 1, b_br(1'b1), "bne_z0");
    cyc(0, 1, rtype(1, 2, 7, 6'h22), 0, 1, b_alu(3'd3, 5'd7), "sub");
    cyc(0, 1, rtype(1, 2, 8, 6'h27), 0, 1, b_alu(3'd6, 5'd8), "nor");

    // Load-use with LOAD_LAT=1
    cyc(0, 1, lw5, 0, 1, b_load(5'd5, 1'b0), "lw5_a");
    cyc(0, 1, add_652, 0, 0, b_bub(), "lu1_bubble");
    cyc(0, 1, add_652, 0, 1, b_alu(3'd2, 5'd6), "lu1_add");

    // Independent follower and $0 destination: no bubble
    cyc(0, 1, lw5, 0, 1, b_load(5'd5, 1'b0), "lw5_b");
    cyc(0, 1, add_678, 0, 1, b_alu(3'd2, 5'd6), "no_hazard");
    cyc(0, 1, lw0, 0, 1, b_load(5'd0, 1'b0), "lw0");
    cyc(0, 1, add_600, 0, 1, b_alu(3'd2, 5'd6), "zero_reg");

    // Back-to-back dependent loads bubble each time
    cyc(0, 1, lw5, 0, 1, b_load(5'd5, 1'b0), "lw5_c");
    cyc(0, 1, lbu9, 0, 0, b_bub(), "b2b_bub1");
    cyc(0, 1, lbu9, 0, 1, b_load(5'd9, 1'b1), "lbu9");
    cyc(0, 1, add_10_99, 0, 0, b_bub(), "b2b_bub2");
    cyc(0, 1, add_10_99, 0, 1, b_alu(3'd2, 5'd10), "b2b_add");

    // Illegal opcode and idle cycle
    cyc(0, 1, 32'hfc00_0000, 0, 1, b_exc(), "illegal");
    cyc(0, 0, add_321, 0, 1, '0, "idle");

    // addm
`ifdef MIPS_DECODE_ADDM_EN
    e = '0; e.out_valid = 1'b1; e.alu_op = 3'd2; e.mem_read = 1'b1; e.addm = 1'b1;
    cyc(0, 1, 32'h0022_202c, 0, 1, e, "addm_p1");
    e = '0; e.out_valid = 1'b1; e.writeenable = 1'b1; e.dest_reg = 5'd4; e.addm = 1'b1;
    cyc(0, 1, add_321, 0, 0, e, "addm_p2");
    cyc(0, 1, add_321, 0, 1, b_alu(3'd2, 5'd3), "addm_next");
`else
    cyc(0, 1, 32'h0022_202c, 0, 1, b_exc(), "addm_illegal");
    cyc(0, 1, add_321, 0, 1, b_alu(3'd2, 5'd3), "addm_next");
`endif
    in_valid1 = 1'b0;

    // Load-use with LOAD_LAT=3, hazard through rt
    cyc(1, 1, lw5, 0, 1, b_load(5'd5, 1'b0), "l3_lw5");
    cyc(1, 1, add_652b, 0, 0, b_bub(), "l3_bub1");
    cyc(1, 1, add_652b, 0, 0, b_bub(), "l3_bub2");
    cyc(1, 1, add_652b, 0, 0, b_bub(), "l3_bub3");
    cyc(1, 1, add_652b, 0, 1, b_alu(3'd2, 5'd6), "l3_add");

    // Reset in the middle of a bubble sequence
    cyc(1, 1, lw5, 0, 1, b_load(5'd5, 1'b0), "l3_lw5_b");
    cyc(1, 1, add_652, 0, 0, b_bub(), "l3_pre_rst_bub");
    reset = 1'b1;
    #1;
    check_b("rst_async_out", obs3, '0);
    check_r("rst_async_rdy", in_ready3, 1'b0);
    @(posedge clk);
    #1;
    check_b("rst_hold_out", obs3, '0);
    reset = 1'b0;
    #1;
    check_r("rst_mid_bubble_rdy", in_ready3, 1'b1);
    cyc(1, 1, add_652, 0, 1, b_alu(3'd2, 5'd6), "post_rst_add");
    in_valid3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
